sap_ram16x8: RTL and testbench

//  SAP-1 16x8 program/data RAM; sits directly downstream of the MAR, whose 4-bit Q drives A.
//  RUN mode: on CE_n low, the byte at A is read and driven onto the W bus via WBUS_out/WBUS_oe.

---
 rtl/sap_pkg.sv | 17 +
 rtl/sap_ram_array.sv | 34 +++
 rtl/sap_ram16x8.sv | 117 +++++++++++
 tb/tb_sap_ram16x8.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// SAP-1 RAM shared types and default geometry.
// Imported by the RAM array, the RAM top and the bench.
package sap_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    PROG,
    DONE
  } ram_state_t;

  typedef logic [SAP_DATA_W-1:0] sap_word_t;

endpackage

// File: rtl/sap_ram_array.sv
// SAP-1 RAM storage: one sync write port, one registered read port.
// Storage is never reset; only the read register returns to zero.
module sap_ram_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register keeps its value between reads so the W bus holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sap_ram16x8.sv
// SAP-1 16x8 RAM: post-reset clear, RUN reads from the MAR,
// PROG loader with valid/ready handshake into a shared pointer.
module sap_ram16x8
  import sap_pkg::*;
#(
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic              CLK,
  input  logic              CLR_n,
  input  logic [ADDR_W-1:0] A,
  input  logic              CE_n,
  output logic [DATA_W-1:0] WBUS_out,
  output logic              WBUS_oe,
  input  logic              prog,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  ram_state_t        state;
  ram_state_t        state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic              oe_q;

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state <= CLEAR;
      ptr   <= '0;
      oe_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      oe_q  <= rd_en;
    end
  end

  // Clear and load share one pointer; modes never overlap.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    we        = 1'b0;
    wdata     = '0;
    rd_en     = 1'b0;
    unique case (state)
      CLEAR: begin
        we      = 1'b1;
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST) begin
          state_nxt = prog ? PROG : RUN;
        end
      end
      RUN: begin
        rd_en   = !CE_n;
        ptr_nxt = '0;
        if (prog) begin
          state_nxt = PROG;
        end
      end
      PROG: begin
        if (prog_valid) begin
          we      = 1'b1;
          wdata   = prog_data;
          ptr_nxt = ptr + 1'b1;
          if (ptr == LAST) begin
            state_nxt = DONE;
          end
        end
        // A byte arriving with the mode drop still lands.
        if (!prog) begin
          state_nxt = RUN;
          ptr_nxt   = '0;
        end
      end
      DONE: begin
        if (!prog) begin
          state_nxt = RUN;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  sap_ram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (CLK),
    .rst_n(CLR_n),
    .we   (we),
    .waddr(ptr),
    .wdata(wdata),
    .re   (rd_en),
    .raddr(A),
    .rdata(WBUS_out)
  );

  assign WBUS_oe    = oe_q;
  assign busy       = (state == CLEAR);
  assign prog_ready = (state == PROG);
  assign prog_done  = (state == DONE);
  assign prog_addr  = (state == PROG || state == DONE) ? ptr : '0;

endmodule

// File: tb/tb_sap_ram16x8.sv
// Bench for the SAP-1 16x8 RAM.
// Reference model: a 16-byte array plus a load index.
module tb_sap_ram16x8;
  import sap_pkg::*;

  logic       tb_clk = 1'b0;
  logic       CLR_n = 1'b1;
  logic [3:0] A = '0;
  logic       CE_n = 1'b1;
  logic [7:0] WBUS_out;
  logic       WBUS_oe;
  logic       prog = 1'b0;
  logic       prog_valid = 1'b0;
  logic [7:0] prog_data = '0;
  logic       prog_ready;
  logic [3:0] prog_addr;
  logic       prog_done;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] model [16];
  int mptr = 0;
  logic [7:0] last_out = '0;

  always #5 tb_clk = ~tb_clk;

  sap_ram16x8 dut (
    .CLK       (tb_clk),
    .CLR_n     (CLR_n),
    .A         (A),
    .CE_n      (CE_n),
    .WBUS_out  (WBUS_out),
    .WBUS_oe   (WBUS_oe),
    .prog      (prog),
    .prog_valid(prog_valid),
    .prog_data (prog_data),
    .prog_ready(prog_ready),
    .prog_addr (prog_addr),
    .prog_done (prog_done),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    mptr = 0;
    last_out = 8'h00;
  endtask

  task automatic load_byte(input logic [7:0] d);
    prog_valid = 1'b1;
    prog_data  = d;
    tick();
    model[mptr] = d;
    mptr = (mptr + 1) % 16;
    prog_valid = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d want 16", tag, n);
    end
    model_clear();
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      A = 4'(i);
      CE_n = 1'b0;
      tick();
      checks++;
      if (WBUS_out !== model[i] || WBUS_oe !== 1'b1) begin
        errors++;
        $display("FAIL %s_read[%0d]: got %h/oe=%b want %h/oe=1",
                 tag, i, WBUS_out, WBUS_oe, model[i]);
      end
      last_out = model[i];
    end
    CE_n = 1'b1;
    tick();
    checks++;
    if (WBUS_oe !== 1'b0 || WBUS_out !== last_out) begin
      errors++;
      $display("FAIL %s_idle: got %h/oe=%b want %h/oe=0",
               tag, WBUS_out, WBUS_oe, last_out);
    end
  endtask

  task automatic hw_reset();
    CE_n = 1'b1;
    prog = 1'b0;
    prog_valid = 1'b0;
    #2;
    CLR_n = 1'b0;
    tick();
    CLR_n = 1'b1;
    wait_clear("rst");
  endtask

  task automatic test_reset();
    #1;
    CLR_n = 1'b0;
    #1;
    checks++;
    if ({busy, WBUS_oe, prog_ready, prog_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got busy/oe/rdy/done=%b want 1000",
               {busy, WBUS_oe, prog_ready, prog_done});
    end
    checks++;
    if (WBUS_out !== 8'h00 || prog_addr !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: got out=%h addr=%h want 00/0",
               WBUS_out, prog_addr);
    end
    tick();
    tick();
    CE_n = 1'b0;
    CLR_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (busy === 1'b1) begin
        checks++;
        if (WBUS_oe !== 1'b0) begin
          errors++;
          $display("FAIL clear_ce_ignored: got oe=%b want 0", WBUS_oe);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_len: got busy=%b want 0 after 16", busy);
    end
    CE_n = 1'b1;
    tick();
    model_clear();
    read_all("cleared");
  endtask

  task automatic test_prog_load();
    int gaps;
    prog = 1'b1;
    tick();
    mptr = 0;
    checks++;
    if (prog_ready !== 1'b1 || prog_addr !== 4'h0) begin
      errors++;
      $display("FAIL prog_enter: got rdy=%b addr=%h want 1/0",
               prog_ready, prog_addr);
    end
    for (int i = 0; i < 16; i++) begin
      gaps = $urandom_range(0, 2);
      repeat (gaps) begin
        tick();
        checks++;
        if (prog_addr !== 4'(i)) begin
          errors++;
          $display("FAIL prog_gap_addr: got %h want %h", prog_addr, 4'(i));
        end
      end
      load_byte(8'(8'h10 + i));
      checks++;
      if (prog_addr !== 4'((i + 1) % 16)) begin
        errors++;
        $display("FAIL prog_addr_step: got %h want %h",
                 prog_addr, 4'((i + 1) % 16));
      end
    end
    checks++;
    if (prog_done !== 1'b1 || prog_ready !== 1'b0) begin
      errors++;
      $display("FAIL prog_done: got done=%b rdy=%b want 1/0",
               prog_done, prog_ready);
    end
    prog = 1'b0;
    tick();
    A = 4'd5;
    CE_n = 1'b0;
    tick();
    checks++;
    if (WBUS_out !== 8'h15 || WBUS_oe !== 1'b1) begin
      errors++;
      $display("FAIL prog_readback5: got %h/oe=%b want 15/1",
               WBUS_out, WBUS_oe);
    end
    last_out = WBUS_out;
    CE_n = 1'b1;
    tick();
  endtask

  task automatic test_partial();
    hw_reset();
    prog = 1'b1;
    tick();
    mptr = 0;
    load_byte(8'hAA);
    load_byte(8'hBB);
    prog = 1'b0;
    load_byte(8'hCC);
    checks++;
    if (prog_ready !== 1'b0 || prog_addr !== 4'h0) begin
      errors++;
      $display("FAIL partial_exit: got rdy=%b addr=%h want 0/0",
               prog_ready, prog_addr);
    end
    for (int i = 0; i < 4; i++) begin
      A = 4'(i);
      CE_n = 1'b0;
      tick();
      checks++;
      if (WBUS_out !== model[i]) begin
        errors++;
        $display("FAIL partial_read[%0d]: got %h want %h",
                 i, WBUS_out, model[i]);
      end
    end
    CE_n = 1'b1;
    prog = 1'b1;
    tick();
    mptr = 0;
    checks++;
    if (prog_addr !== 4'h0 || prog_ready !== 1'b1) begin
      errors++;
      $display("FAIL partial_reenter: got addr=%h rdy=%b want 0/1",
               prog_addr, prog_ready);
    end
    prog = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_out;
    logic       rd;
    prog = 1'b1;
    tick();
    mptr = 0;
    for (int i = 0; i < 16; i++) load_byte(8'($urandom));
    prog = 1'b0;
    tick();
    CE_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A = 4'(i);
      tick();
      checks++;
      if (WBUS_out !== model[i] || WBUS_oe !== 1'b1) begin
        errors++;
        $display("FAIL b2b_read[%0d]: got %h/oe=%b want %h/1",
                 i, WBUS_out, WBUS_oe, model[i]);
      end
    end
    exp_out = model[3];
    CE_n = 1'b1;
    tick();
    checks++;
    if (WBUS_oe !== 1'b0 || WBUS_out !== exp_out) begin
      errors++;
      $display("FAIL b2b_drop: got %h/oe=%b want %h/0",
               WBUS_out, WBUS_oe, exp_out);
    end
    for (int k = 0; k < 30; k++) begin
      rd = 1'($urandom);
      A = 4'($urandom);
      CE_n = !rd;
      tick();
      if (rd) exp_out = model[A];
      checks++;
      if (WBUS_out !== exp_out || WBUS_oe !== rd) begin
        errors++;
        $display("FAIL rand_read: A=%h got %h/oe=%b want %h/oe=%b",
                 A, WBUS_out, WBUS_oe, exp_out, rd);
      end
    end
    CE_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_prog();
    prog = 1'b1;
    tick();
    mptr = 0;
    for (int i = 0; i < 7; i++) load_byte(8'($urandom_range(1, 255)));
    checks++;
    if (prog_addr !== 4'd7) begin
      errors++;
      $display("FAIL midrst_ptr: got %h want 7", prog_addr);
    end
    prog_valid = 1'b1;
    prog_data = 8'h5A;
    #2;
    CLR_n = 1'b0;
    #1;
    checks++;
    if ({busy, WBUS_oe, prog_ready, prog_done} !== 4'b1000 ||
        prog_addr !== 4'h0 || WBUS_out !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outputs: got b/oe/r/d=%b addr=%h out=%h want 1000/0/00",
               {busy, WBUS_oe, prog_ready, prog_done}, prog_addr, WBUS_out);
    end
    tick();
    prog = 1'b0;
    prog_valid = 1'b0;
    CLR_n = 1'b1;
    wait_clear("midrst");
    read_all("midrst");
  endtask

  task automatic test_done_hold();
    prog = 1'b1;
    CE_n = 1'b1;
    tick();
    mptr = 0;
    CE_n = 1'b0;
    A = 4'd0;
    tick();
    checks++;
    if (WBUS_oe !== 1'b0) begin
      errors++;
      $display("FAIL prog_oe_forced: got oe=%b want 0", WBUS_oe);
    end
    for (int i = 0; i < 16; i++) begin
      load_byte(8'($urandom_range(0, 254)));
      checks++;
      if (WBUS_oe !== 1'b0) begin
        errors++;
        $display("FAIL load_oe_forced: got oe=%b want 0", WBUS_oe);
      end
    end
    CE_n = 1'b1;
    prog_valid = 1'b1;
    prog_data = 8'hFF;
    repeat (3) begin
      tick();
      checks++;
      if (prog_ready !== 1'b0 || prog_done !== 1'b1) begin
        errors++;
        $display("FAIL done_hold: got rdy=%b done=%b want 0/1",
                 prog_ready, prog_done);
      end
    end
    prog_valid = 1'b0;
    prog = 1'b0;
    tick();
    read_all("done");
  endtask

  initial begin
    test_reset();
    test_prog_load();
    test_partial();
    test_back_to_back();
    test_reset_mid_prog();
    test_done_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
